// File: rtl/gpio_pkg.sv
// Shared constants, register map and helpers for the GPIO interrupt block.
package gpio_pkg;

  localparam int unsigned GPIO_IRQ_REG_W = 32;
  localparam int unsigned GPIO_IRQ_BE_W  = GPIO_IRQ_REG_W / 8;

  localparam logic [GPIO_IRQ_REG_W-1:0] GPIO_IRQ_STATE_REG  = 32'h0000_0000;
  localparam logic [GPIO_IRQ_REG_W-1:0] GPIO_IRQ_ENABLE_REG = 32'h0000_0004;
  localparam logic [GPIO_IRQ_REG_W-1:0] GPIO_IRQ_RISE_REG   = 32'h0000_0008;
  localparam logic [GPIO_IRQ_REG_W-1:0] GPIO_IRQ_FALL_REG   = 32'h0000_000C;
  localparam logic [GPIO_IRQ_REG_W-1:0] GPIO_IRQ_TEST_REG   = 32'h0000_0010;
  localparam logic [GPIO_IRQ_REG_W-1:0] GPIO_IRQ_INPUT_REG  = 32'h0000_0014;

  typedef enum logic [2:0] {
    IRQ_REG_NONE,
    IRQ_REG_STATE,
    IRQ_REG_ENABLE,
    IRQ_REG_RISE,
    IRQ_REG_FALL,
    IRQ_REG_TEST,
    IRQ_REG_INPUT
  } irq_reg_e;

  // Expand byte enables into a per-bit lane mask.
  function automatic logic [GPIO_IRQ_REG_W-1:0] be_to_mask(input logic [GPIO_IRQ_BE_W-1:0] be);
    logic [GPIO_IRQ_REG_W-1:0] mask;
    mask = '0;
    for (int b = 0; b < int'(GPIO_IRQ_BE_W); b++) begin
      mask[b*8 +: 8] = {8{be[b]}};
    end
    return mask;
  endfunction

  // Map a register-window offset onto a register select; anything else is unmapped.
  function automatic irq_reg_e decode_reg(input logic [GPIO_IRQ_REG_W-1:0] off);
    irq_reg_e sel;
    case (off)
      GPIO_IRQ_STATE_REG:  sel = IRQ_REG_STATE;
      GPIO_IRQ_ENABLE_REG: sel = IRQ_REG_ENABLE;
      GPIO_IRQ_RISE_REG:   sel = IRQ_REG_RISE;
      GPIO_IRQ_FALL_REG:   sel = IRQ_REG_FALL;
      GPIO_IRQ_TEST_REG:   sel = IRQ_REG_TEST;
      GPIO_IRQ_INPUT_REG:  sel = IRQ_REG_INPUT;
      default:             sel = IRQ_REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/gpio_irq_edge.sv
// Per-pin rise/fall event detector with a primed flag that masks the first
// post-reset cycle, so the reset value of the previous sample never fakes an edge.
module gpio_irq_edge #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] gpi,
  input  logic [Width-1:0] rise_en,
  input  logic [Width-1:0] fall_en,
  output logic [Width-1:0] evt_c
);

  logic [Width-1:0] gpi_q;
  logic             primed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpi_q  <= '0;
      primed <= 1'b0;
    end else begin
      gpi_q  <= gpi;
      primed <= 1'b1;
    end
  end

  assign evt_c = {Width{primed}} &
                 ((gpi & ~gpi_q & rise_en) | (~gpi & gpi_q & fall_en));

endmodule

// File: rtl/gpio_irq.sv
// Edge/level interrupt generator for debounced GPIO inputs with a small
// device-bus register window and a single registered level interrupt.
module gpio_irq
  import gpio_pkg::*;
#(
  parameter int unsigned GpiWidth  = 8,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned RegAddr   = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 device_req_i,
  input  logic [AddrWidth-1:0] device_addr_i,
  input  logic                 device_we_i,
  input  logic [3:0]           device_be_i,
  input  logic [DataWidth-1:0] device_wdata_i,
  output logic                 device_rvalid_o,
  output logic [DataWidth-1:0] device_rdata_o,
  input  logic [GpiWidth-1:0]  gpi_i,
  output logic                 irq_o
);

  logic [GpiWidth-1:0] intr_state;
  logic [GpiWidth-1:0] intr_enable;
  logic [GpiWidth-1:0] rise_en;
  logic [GpiWidth-1:0] fall_en;

  logic [GpiWidth-1:0] state_next;
  logic [GpiWidth-1:0] enable_next;
  logic [GpiWidth-1:0] rise_next;
  logic [GpiWidth-1:0] fall_next;

  logic [GpiWidth-1:0] evt_c;
  logic [GpiWidth-1:0] lane_mask;
  logic [GpiWidth-1:0] wdata_pins;
  logic [GpiWidth-1:0] w1c_clear;
  logic [GpiWidth-1:0] test_set;
  logic [DataWidth-1:0] rdata_c;

  irq_reg_e reg_sel;
  logic     wr;
  logic     rd;

  // Upper address bits and wdata bits beyond the pin count carry no meaning here.
  logic unused_bus;
  assign unused_bus = ^{device_addr_i, device_wdata_i};

  assign wr         = device_req_i & device_we_i;
  assign rd         = device_req_i & ~device_we_i;
  assign reg_sel    = decode_reg(GPIO_IRQ_REG_W'(device_addr_i[RegAddr-1:0]));
  assign lane_mask  = GpiWidth'(be_to_mask(device_be_i));
  assign wdata_pins = GpiWidth'(device_wdata_i) & lane_mask;

  gpio_irq_edge #(
    .Width (GpiWidth)
  ) u_edge (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .gpi     (gpi_i),
    .rise_en (rise_en),
    .fall_en (fall_en),
    .evt_c   (evt_c)
  );

  // Register write effects; a hardware event always beats a same-cycle clear.
  always_comb begin
    w1c_clear   = '0;
    test_set    = '0;
    enable_next = intr_enable;
    rise_next   = rise_en;
    fall_next   = fall_en;
    if (wr) begin
      case (reg_sel)
        IRQ_REG_STATE:  w1c_clear   = wdata_pins;
        IRQ_REG_ENABLE: enable_next = (intr_enable & ~lane_mask) | wdata_pins;
        IRQ_REG_RISE:   rise_next   = (rise_en & ~lane_mask) | wdata_pins;
        IRQ_REG_FALL:   fall_next   = (fall_en & ~lane_mask) | wdata_pins;
        IRQ_REG_TEST:   test_set    = wdata_pins;
        default:        ;
      endcase
    end
    state_next = (intr_state & ~w1c_clear) | evt_c | test_set;
  end

  // Read mux; write-only and unmapped offsets read as zero.
  always_comb begin
    rdata_c = '0;
    case (reg_sel)
      IRQ_REG_STATE:  rdata_c = DataWidth'(intr_state);
      IRQ_REG_ENABLE: rdata_c = DataWidth'(intr_enable);
      IRQ_REG_RISE:   rdata_c = DataWidth'(rise_en);
      IRQ_REG_FALL:   rdata_c = DataWidth'(fall_en);
      IRQ_REG_INPUT:  rdata_c = DataWidth'(gpi_i);
      default:        rdata_c = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      intr_state      <= '0;
      intr_enable     <= '0;
      rise_en         <= '0;
      fall_en         <= '0;
      irq_o           <= 1'b0;
      device_rvalid_o <= 1'b0;
      device_rdata_o  <= '0;
    end else begin
      intr_state      <= state_next;
      intr_enable     <= enable_next;
      rise_en         <= rise_next;
      fall_en         <= fall_next;
      irq_o           <= |(state_next & enable_next);
      device_rvalid_o <= rd;
      device_rdata_o  <= rd ? rdata_c : '0;
    end
  end

endmodule

// File: tb/tb_gpio_irq.sv
// Self-checking bench for gpio_irq: directed scenarios plus randomized bus
// traffic and input toggling, compared cycle by cycle against a reference model.
module tb_gpio_irq;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_s;
  logic [31:0] addr_s;
  logic        we_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;
  logic        rvalid;
  logic [31:0] rdata;
  logic [W-1:0] gpi_s;
  logic        irq;

  always #5 clk = ~clk;

  gpio_irq #(
    .GpiWidth  (W),
    .AddrWidth (32),
    .DataWidth (32),
    .RegAddr   (12)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .device_req_i    (req_s),
    .device_addr_i   (addr_s),
    .device_we_i     (we_s),
    .device_be_i     (be_s),
    .device_wdata_i  (wdata_s),
    .device_rvalid_o (rvalid),
    .device_rdata_o  (rdata),
    .gpi_i           (gpi_s),
    .irq_o           (irq)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference model of the architectural state.
  bit [W-1:0] m_state, m_en, m_rise, m_fall, m_prev;
  bit         m_primed, m_irq, m_rvalid;
  bit [31:0]  m_rdata;
  bit [W-1:0] g;

  function automatic void model_reset();
    m_state = '0; m_en = '0; m_rise = '0; m_fall = '0; m_prev = '0;
    m_primed = 1'b0; m_irq = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
  endfunction

  // One bus/input cycle, entered and left at a falling edge.
  task automatic cycle(input bit req, input bit we, input bit [11:0] off,
                       input bit [3:0] be, input bit [31:0] wd, input bit [W-1:0] gpi);
    bit [W-1:0] ev, lm, wm, clr, tst, n_state, n_en, n_rise, n_fall;
    bit [31:0]  hi, rd_val;
    bit         rv;
    hi      = $urandom() & 32'hFFFF_F000;
    req_s   = req;
    we_s    = we;
    addr_s  = hi | 32'(off);
    be_s    = be;
    wdata_s = wd;
    gpi_s   = gpi;
    for (int i = 0; i < W; i++) begin
      lm[i] = be[i/8];
      wm[i] = be[i/8] & wd[i];
      ev[i] = m_primed && ((gpi[i] && !m_prev[i] && m_rise[i]) ||
                           (!gpi[i] && m_prev[i] && m_fall[i]));
    end
    clr = '0; tst = '0; n_en = m_en; n_rise = m_rise; n_fall = m_fall;
    if (req && we) begin
      case (off)
        12'h000: clr    = wm;
        12'h004: n_en   = (m_en & ~lm) | wm;
        12'h008: n_rise = (m_rise & ~lm) | wm;
        12'h00C: n_fall = (m_fall & ~lm) | wm;
        12'h010: tst    = wm;
        default: ;
      endcase
    end
    n_state = (m_state & ~clr) | ev | tst;
    rv = req && !we;
    rd_val = '0;
    if (rv) begin
      case (off)
        12'h000: rd_val = 32'(m_state);
        12'h004: rd_val = 32'(m_en);
        12'h008: rd_val = 32'(m_rise);
        12'h00C: rd_val = 32'(m_fall);
        12'h014: rd_val = 32'(gpi);
        default: rd_val = '0;
      endcase
    end
    @(posedge clk);
    m_state = n_state; m_en = n_en; m_rise = n_rise; m_fall = n_fall;
    m_irq = |(n_state & n_en);
    m_prev = gpi; m_primed = 1'b1;
    m_rvalid = rv; m_rdata = rd_val;
    @(negedge clk);
    check("irq", 32'(irq), 32'(m_irq));
    check("rvalid", 32'(rvalid), 32'(m_rvalid));
    if (m_rvalid) check($sformatf("rdata@%03h", off), rdata, m_rdata);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 12'h0, 4'h0, 32'h0, g);
  endtask

  task automatic wr(input bit [11:0] off, input bit [3:0] be, input bit [31:0] d);
    cycle(1'b1, 1'b1, off, be, d, g);
  endtask

  task automatic rd(input bit [11:0] off);
    cycle(1'b1, 1'b0, off, 4'hF, 32'h0, g);
  endtask

  bit [11:0] offs [8] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014, 12'h018, 12'hFFC};

  initial begin
    req_s = 0; we_s = 0; addr_s = 0; be_s = 0; wdata_s = 0;
    g = 8'hFF; gpi_s = g;
    rst_n = 1'b0;
    model_reset();
    #12;
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Read every offset back to back with inputs held high through release.
    foreach (offs[k]) rd(offs[k]);
    rd(12'h000);
    check("primed_mask_state", rdata, 32'h0);

    // Rising edge on pin 0, then clear.
    g = 8'h00; idle();
    wr(12'h008, 4'h1, 32'h01);
    wr(12'h004, 4'h1, 32'h01);
    g = 8'h01; idle();
    check("rise_irq", 32'(irq), 32'h1);
    rd(12'h000);
    check("rise_state", rdata, 32'h01);
    wr(12'h000, 4'h1, 32'h01);
    check("w1c_irq", 32'(irq), 32'h0);

    // Falling edge on pin 7 while disabled, then enable.
    wr(12'h004, 4'h1, 32'h00);
    wr(12'h00C, 4'h1, 32'h80);
    g = 8'h81; idle();
    g = 8'h01; idle();
    idle();
    check("fall_irq_disabled", 32'(irq), 32'h0);
    rd(12'h000);
    check("fall_state", rdata, 32'h80);
    wr(12'h004, 4'h1, 32'h80);
    check("enable_raises_irq", 32'(irq), 32'h1);
    wr(12'h000, 4'h1, 32'hFF);

    // Event and clear on the same bit in the same cycle: set wins.
    wr(12'h008, 4'h1, 32'h04);
    wr(12'h004, 4'h1, 32'h04);
    g = 8'h05; idle();
    g = 8'h01; idle();
    g = 8'h05;
    wr(12'h000, 4'h1, 32'h04);
    check("set_beats_clear_irq", 32'(irq), 32'h1);
    rd(12'h000);
    check("set_beats_clear_state", rdata, 32'h04);

    // Interrupt test register and byte enables.
    wr(12'h000, 4'h1, 32'hFF);
    wr(12'h004, 4'h1, 32'h00);
    wr(12'h010, 4'h0, 32'h30);
    rd(12'h000);
    check("test_be0", rdata, 32'h00);
    wr(12'h010, 4'h1, 32'h30);
    rd(12'h000);
    check("test_be1", rdata, 32'h30);
    rd(12'h010);
    check("test_reads0", rdata, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      bit [31:0] r;
      r = $urandom();
      g = g ^ W'($urandom() & $urandom() & $urandom());
      if (r[1:0] == 2'b00) idle();
      else cycle(1'b1, r[2], offs[r[5:3]], 4'($urandom()), $urandom(), g);
    end

    // Asynchronous reset while an interrupt is pending.
    wr(12'h000, 4'h1, 32'hFF);
    wr(12'h010, 4'h1, 32'h0F);
    wr(12'h004, 4'h1, 32'h0F);
    rd(12'h000);
    check("pre_rst_state", rdata, 32'h0F);
    check("pre_rst_irq", 32'(irq), 32'h1);
    #2;
    req_s = 1'b0; we_s = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_irq", 32'(irq), 32'h0);
    check("async_rvalid", 32'(rvalid), 32'h0);
    check("async_rdata", rdata, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    g = ~g; idle();
    rd(12'h000);
    wr(12'h008, 4'h1, 32'hFF);
    wr(12'h00C, 4'h1, 32'hFF);
    wr(12'h004, 4'h1, 32'hFF);
    for (int n = 0; n < 100; n++) begin
      bit [31:0] r;
      r = $urandom();
      g = g ^ W'($urandom() & $urandom());
      if (r[0]) idle();
      else cycle(1'b1, r[1], offs[r[4:2]], 4'($urandom()), $urandom(), g);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
